// File: rtl/ucsbece154b_sdram_ctrl.sv
// ----------------------------------------------------------------------------
// ucsbece154b_sdram_ctrl
//
// Behavioural SDRAM controller/model that refills the instruction cache on a
// miss. After a block read request is accepted, it waits a fixed first-word
// latency. It then streams the aligned block in ascending order, one word per
// cycle.
//
// Parameters
//    BLOCK_WORDS  words per burst (power of two, matches the icache block)
//    WORD_SIZE    bits per word
//    MEM_WORDS    backing-store depth in words (power of two)
//    T0_DELAY     cycles from request acceptance to the first word (>= 1)
//    INIT_FILE    image name for the store ("" leaves it unloaded)
//
// Ports
//    clk             rising-edge clock
//    reset           asynchronous, active-low reset
//    memReadRequest  miss request level, held while the icache waits
//    memReadAddress  byte address of the missing word
//    memDataIn       burst data word (registered, holds its value outside bursts)
//    memDataReady    high exactly while burst words are valid (registered)
//    memBusy         high while waiting or bursting (combinational from state)
// ----------------------------------------------------------------------------
module ucsbece154b_sdram_ctrl #(
   parameter int    BLOCK_WORDS = 4,
   parameter int    WORD_SIZE   = 32,
   parameter int    MEM_WORDS   = 65536,
   parameter int    T0_DELAY    = 40,
   parameter string INIT_FILE   = "text.dat"
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 memReadRequest,
   input  logic [31:0]          memReadAddress,
   output logic [WORD_SIZE-1:0] memDataIn,
   output logic                 memDataReady,
   output logic                 memBusy
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int LW = (T0_DELAY > 1) ? $clog2(T0_DELAY) : 1;
   localparam int CW = $clog2(BLOCK_WORDS + 1);

   localparam logic [AW-1:0] BLK_MASK = AW'(BLOCK_WORDS - 1);
   localparam logic [LW-1:0] LAT_INIT = LW'(T0_DELAY - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST
   } state_t;

   // Read-only backing store.
   logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];

   state_t               state_q, state_d;
   logic [AW-1:0]        base_q, base_d;
   logic [LW-1:0]        lat_q, lat_d;
   logic [CW-1:0]        word_q, word_d;
   logic                 ready_q, ready_d;
   logic [WORD_SIZE-1:0] data_q;
   logic                 rd_en;
   logic [AW-1:0]        rd_idx;

   // Address bits outside the word index are intentionally discarded.
   // Taking the index modulo the depth is what makes addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{memReadAddress[31:AW+2], memReadAddress[1:0]};

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      lat_d   = lat_q;
      word_d  = word_q;
      ready_d = ready_q;
      rd_en   = 1'b0;
      // The base is block aligned, so OR-ing in the offset stays within the block.
      // No carry ever reaches the set bits.
      rd_idx  = base_q | (AW'(word_q) & BLK_MASK);

      unique case (state_q)
         ST_IDLE: begin
            if (memReadRequest) begin
               base_d  = memReadAddress[AW+1:2] & ~BLK_MASK;
               lat_d   = LAT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!memReadRequest) begin
               // The icache resolved the access itself, so abandon the fetch.
               state_d = ST_IDLE;
            end else if (lat_q == '0) begin
               state_d = ST_BURST;
               ready_d = 1'b1;
               rd_en   = 1'b1;
               rd_idx  = base_q;
               word_d  = CW'(1);
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         ST_BURST: begin
            // Once started, a burst always runs to completion.
            if (word_q == CNT_LAST) begin
               ready_d = 1'b0;
               word_d  = '0;
               state_d = ST_IDLE;
            end else begin
               rd_en  = 1'b1;
               word_d = word_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         lat_q   <= '0;
         word_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         lat_q   <= lat_d;
         word_q  <= word_d;
         ready_q <= ready_d;
      end
   end

   // Registered store read. The word is held when no read is scheduled, so
   // the last burst word stays on the bus until the next burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else if (rd_en) begin
         data_q <= mem_q[rd_idx];
      end
   end

   assign memDataIn    = data_q;
   assign memDataReady = ready_q;
   assign memBusy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ucsbece154b_sdram_ctrl.sv
module tb_ucsbece154b_sdram_ctrl;

   localparam int BW = 4;
   localparam int WS = 32;
   localparam int MW = 256;
   localparam int T0 = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [31:0]   addr;
   logic [WS-1:0] data;
   logic          ready;
   logic          busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [WS-1:0] ref_mem [MW];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ucsbece154b_sdram_ctrl #(
      .BLOCK_WORDS(BW),
      .WORD_SIZE  (WS),
      .MEM_WORDS  (MW),
      .T0_DELAY   (T0),
      .INIT_FILE  ("")
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .memReadRequest(req),
      .memReadAddress(addr),
      .memDataIn     (data),
      .memDataReady  (ready),
      .memBusy       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: the word index of the block base, from plain arithmetic.
   function automatic int blk_base(input logic [31:0] a);
      logic [31:0] w;
      w = (a >> 2) & ~(32'(BW - 1));
      return int'(w % 32'(MW));
   endfunction

   // One complete miss. Timing is checked against E0 + T0 + i, and data
   // against the reference store.
   task automatic do_burst(input logic [31:0] a, input bit drop_after_first, input string tag);
      int base;
      int n;
      base = blk_base(a);
      req  = 1'b1;
      addr = a;
      tick();                 // just after E0
      addr = $urandom;        // must be ignored once latched
      chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      n = 0;
      while (ready !== 1'b1 && n < T0 + 8) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(T0));
      for (int i = 0; i < BW; i++) begin
         chk({tag, "_ready"}, 32'(ready), 32'd1);
         chk({tag, "_data"}, data, ref_mem[base + i]);
         if (drop_after_first && i == 0) req = 1'b0;
         tick();
      end
      chk({tag, "_ready_end"}, 32'(ready), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_data_hold"}, data, ref_mem[base + BW - 1]);
      req = 1'b0;
      $display("burst %s addr=%h base=%0d drop=%0d", tag, a, base, drop_after_first);
   endtask

   initial begin
      int base;
      int cnt;
      int t1;
      int t2;
      logic [31:0] a;

      reset = 1'b0;
      req   = 1'b0;
      addr  = '0;
      for (int i = 0; i < MW; i++) ref_mem[i] = $urandom;
      for (int i = 0; i < BW; i++) ref_mem[16 + i] = 32'hA0 + 32'(i);
      for (int i = 0; i < MW; i++) dut.mem_q[i] = ref_mem[i];

      // Reset state
      repeat (3) tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", data, 32'd0);
      reset = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      $display("reset released");

      // Single miss; data A0..A3 from mem[0x10..0x13]
      do_burst(32'h0000_0048, 1'b0, "single");

      // Alignment and wrap modulo the store depth
      do_burst(32'h0000_040C, 1'b0, "wrap");

      // Request dropped after the first word
      do_burst($urandom, 1'b1, "drop");

      // Abort during the wait
      req  = 1'b1;
      addr = $urandom;
      tick();
      chk("abort_busy0", 32'(busy), 32'd1);
      tick();
      chk("abort_busy1", 32'(busy), 32'd1);
      req = 1'b0;
      tick();
      chk("abort_busy2", 32'(busy), 32'd0);
      cnt = 0;
      for (int i = 0; i < T0 + BW + 2; i++) begin
         if (ready === 1'b1) cnt++;
         tick();
      end
      chk("abort_no_ready", 32'(cnt), 32'd0);
      $display("abort done");

      // Asynchronous reset in the middle of a burst
      req  = 1'b1;
      addr = $urandom;
      tick();
      cnt = 0;
      while (ready !== 1'b1 && cnt < T0 + 8) begin
         tick();
         cnt++;
      end
      chk("rstmid_inburst", 32'(ready), 32'd1);
      tick();
      reset = 1'b0;
      #1;
      chk("rstmid_ready", 32'(ready), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_data", data, 32'd0);
      req = 1'b0;
      #2;
      reset = 1'b1;
      repeat (3) tick();
      chk("rstmid_idle_ready", 32'(ready), 32'd0);
      chk("rstmid_idle_busy", 32'(busy), 32'd0);
      $display("mid-burst reset done");

      // Back-to-back requests with the request held high
      a    = $urandom;
      base = blk_base(a);
      req  = 1'b1;
      addr = a;
      tick();
      cnt = 0;
      while (ready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
      chk("b2b_first", 32'(ready), 32'd1);
      t1 = cyc;
      cnt = 0;
      while (ready !== 1'b0 && cnt < 50) begin tick(); cnt++; end
      cnt = 0;
      while (ready !== 1'b1 && cnt < 50) begin tick(); cnt++; end
      chk("b2b_second", 32'(ready), 32'd1);
      t2 = cyc;
      chk("b2b_spacing", 32'(t2 - t1), 32'(T0 + BW + 1));
      chk("b2b_data", data, ref_mem[base]);
      req = 1'b0;
      cnt = 0;
      while (busy !== 1'b0 && cnt < 50) begin tick(); cnt++; end
      chk("b2b_idle", 32'(busy), 32'd0);
      $display("back-to-back spacing=%0d", t2 - t1);

      // Random misses
      for (int r = 0; r < 6; r++) begin
         do_burst($urandom, 1'($urandom_range(0, 1)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
